// File: rtl/us_sensor_pkg.sv
// Shared defaults and helpers for the ultrasonic ranging timebase.
package us_sensor_pkg;

    localparam int unsigned CLK_PER_US_DEF = 100;
    localparam int unsigned US_PER_MS_DEF  = 1000;
    localparam int unsigned TIMEOUT_MS_DEF = 38;

    // Width needed to hold the total-us count up to the timeout point.
    function automatic int unsigned tot_w_for(input int unsigned timeout_ms,
                                              input int unsigned us_per_ms);
        return $clog2(timeout_ms * us_per_ms + 1);
    endfunction

    localparam int unsigned TOT_W_DEF = tot_w_for(TIMEOUT_MS_DEF, US_PER_MS_DEF);

    typedef enum logic [1:0] {
        MODE_CLEAR,
        MODE_FROZEN,
        MODE_RUN,
        MODE_HOLD
    } tb_mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated divide-by-DIV counter; o_tick flags the edge on which the count wraps.
module tick_prescaler #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    always_comb begin
        wrap   = (32'(cnt) == DIV - 1);
        // Strobe is combinational so the owner can update its counters on the same edge.
        o_tick = i_en & ~i_clr & wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/us_timebase.sv
// Microsecond/millisecond timebase with saturating counters, echo capture and
// sticky no-echo timeout for ultrasonic ranging.
module us_timebase
    import us_sensor_pkg::*;
#(
    parameter int unsigned CLK_PER_US = CLK_PER_US_DEF,
    parameter int unsigned US_PER_MS  = US_PER_MS_DEF,
    parameter int unsigned US_W       = 10,
    parameter int unsigned MS_W       = 6,
    parameter int unsigned TIMEOUT_MS = TIMEOUT_MS_DEF,
    parameter int unsigned TOT_W      = tot_w_for(TIMEOUT_MS, US_PER_MS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_run,
    input  logic             i_capture,
    output logic             o_us_tick,
    output logic             o_ms_tick,
    output logic [US_W-1:0]  o_us_cnt,
    output logic [MS_W-1:0]  o_ms_cnt,
    output logic [TOT_W-1:0] o_total_us,
    output logic [TOT_W-1:0] o_cap_us,
    output logic             o_cap_valid,
    output logic             o_timeout
);

    tb_mode_t         mode;
    logic             us_strobe;
    logic             us_wrap;
    logic [MS_W-1:0]  ms_next;
    logic [TOT_W-1:0] total_next;

    tick_prescaler #(
        .DIV(CLK_PER_US)
    ) u_us_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_clear),
        .i_en  (i_run & ~o_timeout),
        .o_tick(us_strobe)
    );

    always_comb begin
        mode = MODE_HOLD;
        if (i_clear) begin
            mode = MODE_CLEAR;
        end else if (o_timeout) begin
            mode = MODE_FROZEN;
        end else if (i_run) begin
            mode = MODE_RUN;
        end
    end

    always_comb begin
        us_wrap    = (32'(o_us_cnt) == US_PER_MS - 1);
        ms_next    = (&o_ms_cnt)   ? o_ms_cnt   : o_ms_cnt + 1'b1;
        total_next = (&o_total_us) ? o_total_us : o_total_us + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_us_tick   <= 1'b0;
            o_ms_tick   <= 1'b0;
            o_us_cnt    <= '0;
            o_ms_cnt    <= '0;
            o_total_us  <= '0;
            o_cap_us    <= '0;
            o_cap_valid <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_us_tick   <= 1'b0;
            o_ms_tick   <= 1'b0;
            o_cap_valid <= 1'b0;
            if (mode == MODE_CLEAR) begin
                o_us_cnt   <= '0;
                o_ms_cnt   <= '0;
                o_total_us <= '0;
                o_timeout  <= 1'b0;
            end else begin
                // Capture takes the pre-increment total, so it sits ahead of the tick update.
                if (i_capture) begin
                    o_cap_us    <= o_total_us;
                    o_cap_valid <= 1'b1;
                end
                if (mode == MODE_RUN && us_strobe) begin
                    o_us_tick  <= 1'b1;
                    o_total_us <= total_next;
                    if (us_wrap) begin
                        o_us_cnt  <= '0;
                        o_ms_tick <= 1'b1;
                        o_ms_cnt  <= ms_next;
                        if (32'(ms_next) == TIMEOUT_MS) begin
                            o_timeout <= 1'b1;
                        end
                    end else begin
                        o_us_cnt <= o_us_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_us_timebase.sv
// Scoreboard bench for us_timebase: a main instance and a narrow-ms instance
// share stimulus; expectations come from an elapsed-run-cycle model.
module tb_us_timebase;

    localparam int CPU    = 4;
    localparam int UPM    = 10;
    localparam int TMO    = 3;
    localparam int TOTMAX = 63;

    typedef struct packed {
        int ust;
        int mst;
        int us;
        int ms;
        int tot;
        int cap;
        int capv;
        int to;
    } snap_t;

    logic clk;
    logic rst_n;
    logic i_clear, i_run, i_capture;

    logic       a_us_tick, a_ms_tick, a_cap_valid, a_timeout;
    logic [3:0] a_us_cnt;
    logic [1:0] a_ms_cnt;
    logic [5:0] a_total_us, a_cap_us;

    logic       b_us_tick, b_ms_tick, b_cap_valid, b_timeout;
    logic [3:0] b_us_cnt;
    logic [0:0] b_ms_cnt;
    logic [5:0] b_total_us, b_cap_us;

    us_timebase #(
        .CLK_PER_US(CPU), .US_PER_MS(UPM), .US_W(4), .MS_W(2), .TIMEOUT_MS(TMO), .TOT_W(6)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_run(i_run), .i_capture(i_capture),
        .o_us_tick(a_us_tick), .o_ms_tick(a_ms_tick), .o_us_cnt(a_us_cnt), .o_ms_cnt(a_ms_cnt),
        .o_total_us(a_total_us), .o_cap_us(a_cap_us), .o_cap_valid(a_cap_valid),
        .o_timeout(a_timeout)
    );

    us_timebase #(
        .CLK_PER_US(CPU), .US_PER_MS(UPM), .US_W(4), .MS_W(1), .TIMEOUT_MS(TMO), .TOT_W(6)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_run(i_run), .i_capture(i_capture),
        .o_us_tick(b_us_tick), .o_ms_tick(b_ms_tick), .o_us_cnt(b_us_cnt), .o_ms_cnt(b_ms_cnt),
        .o_total_us(b_total_us), .o_cap_us(b_cap_us), .o_cap_valid(b_cap_valid),
        .o_timeout(b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors = 0;
    int    errors  = 0;
    snap_t q0[$];
    snap_t q1[$];
    int    m_rc[2];
    int    m_cap[2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Timeout only fires if the ms counter can actually hold the timeout value.
    function automatic int tout_of(input int rc, input int ms_max);
        return ((TMO <= ms_max) && (rc / (CPU * UPM) >= TMO)) ? 1 : 0;
    endfunction

    function automatic snap_t model_step(input int k, input bit clr, input bit run, input bit cap);
        snap_t s;
        int    ms_max;
        int    raw;
        bit    adv;
        ms_max = (k == 0) ? 3 : 1;
        s = '0;
        if (clr) begin
            m_rc[k] = 0;
        end else begin
            if (cap) begin
                m_cap[k] = imin(m_rc[k] / CPU, TOTMAX);
                s.capv = 1;
            end
            adv = run && (tout_of(m_rc[k], ms_max) == 0);
            if (adv) m_rc[k] = m_rc[k] + 1;
            if (adv && (m_rc[k] % CPU == 0)) begin
                s.ust = 1;
                if ((m_rc[k] / CPU) % UPM == 0) s.mst = 1;
            end
        end
        raw   = m_rc[k] / CPU;
        s.us  = raw % UPM;
        s.ms  = imin(raw / UPM, ms_max);
        s.tot = imin(raw, TOTMAX);
        s.cap = m_cap[k];
        s.to  = tout_of(m_rc[k], ms_max);
        return s;
    endfunction

    function automatic snap_t act0();
        snap_t s;
        s.ust = int'(a_us_tick);  s.mst = int'(a_ms_tick);
        s.us  = int'(a_us_cnt);   s.ms  = int'(a_ms_cnt);
        s.tot = int'(a_total_us); s.cap = int'(a_cap_us);
        s.capv = int'(a_cap_valid); s.to = int'(a_timeout);
        return s;
    endfunction

    function automatic snap_t act1();
        snap_t s;
        s.ust = int'(b_us_tick);  s.mst = int'(b_ms_tick);
        s.us  = int'(b_us_cnt);   s.ms  = int'(b_ms_cnt);
        s.tot = int'(b_total_us); s.cap = int'(b_cap_us);
        s.capv = int'(b_cap_valid); s.to = int'(b_timeout);
        return s;
    endfunction

    task automatic check(input string name, input snap_t got, input snap_t exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got ust=%0d mst=%0d us=%0d ms=%0d tot=%0d cap=%0d capv=%0d to=%0d; want ust=%0d mst=%0d us=%0d ms=%0d tot=%0d cap=%0d capv=%0d to=%0d",
                     name, $time, got.ust, got.mst, got.us, got.ms, got.tot, got.cap, got.capv, got.to,
                     exp.ust, exp.mst, exp.us, exp.ms, exp.tot, exp.cap, exp.capv, exp.to);
        end
    endtask

    task automatic apply(input bit clr, input bit run, input bit cap);
        i_clear   = clr;
        i_run     = run;
        i_capture = cap;
        q0.push_back(model_step(0, clr, run, cap));
        q1.push_back(model_step(1, clr, run, cap));
    endtask

    task automatic cycle(input bit clr, input bit run, input bit cap);
        @(negedge clk);
        apply(clr, run, cap);
    endtask

    task automatic runs(input int n);
        repeat (n) cycle(1'b0, 1'b1, 1'b0);
    endtask

    // Async reset between edges: outputs must drop at once, and the edge after
    // release must not tick.
    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_main", act0(), '0);
        check("reset_async_sat", act1(), '0);
        m_rc  = '{0, 0};
        m_cap = '{0, 0};
        q0.push_back('0);
        q1.push_back('0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every registered output set one step after each edge.
    initial begin
        snap_t e0, e1;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                check("main", act0(), e0);
                check("sat", act1(), e1);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        i_clear   = 1'b0;
        i_run     = 1'b0;
        i_capture = 1'b0;
        m_rc      = '{0, 0};
        m_cap     = '{0, 0};
        #1;
        check("reset_main", act0(), '0);
        check("reset_sat", act1(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 1'b0, 1'b0);
        runs(40);

        cycle(1'b1, 1'b0, 1'b0);
        runs(6);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        runs(2);

        cycle(1'b1, 1'b0, 1'b0);
        runs(130);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        runs(5);

        cycle(1'b1, 1'b0, 1'b0);
        runs(22);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        runs(1);
        cycle(1'b1, 1'b1, 1'b1);
        runs(3);

        runs(10);
        mid_reset();
        runs(10);

        cycle(1'b1, 1'b0, 1'b0);
        runs(300);
        cycle(1'b0, 1'b1, 1'b1);

        repeat (1500) begin
            cycle(($urandom % 64) == 0, ($urandom % 8) != 0, ($urandom % 16) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, want 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
